// File: rtl/acs_pm_unit_k3_if.sv
// acs_pm_unit_k3_if: bus between the branch-metric stage, the K=3 ACS /
// path-metric unit and the traceback stage.
// The master drives the branch metrics and receives decisions and metrics.
// The slave is the ACS unit.
// ACS_BEST_STATE_EN adds best_state/best_pm (best-state traceback start).
interface acs_pm_unit_k3_if #(
    parameter int PM_W = 6
);
    logic              in_valid;
    logic              sof;
    logic [1:0]        bm00;
    logic [1:0]        bm01;
    logic [1:0]        bm10;
    logic [1:0]        bm11;
    logic              dec_valid;
    logic [3:0]        dec;
    logic [4*PM_W-1:0] pm_flat;
    logic              norm;
`ifdef ACS_BEST_STATE_EN
    logic [1:0]        best_state;
    logic [PM_W-1:0]   best_pm;
`endif

    // Upstream / traceback side: supplies branch metrics, consumes decisions.
    modport master (
        output in_valid,
        output sof,
        output bm00,
        output bm01,
        output bm10,
        output bm11,
        input  dec_valid,
        input  dec,
        input  pm_flat,
`ifdef ACS_BEST_STATE_EN
        input  best_state,
        input  best_pm,
`endif
        input  norm
    );

    // ACS unit side.
    modport slave (
        input  in_valid,
        input  sof,
        input  bm00,
        input  bm01,
        input  bm10,
        input  bm11,
        output dec_valid,
        output dec,
        output pm_flat,
`ifdef ACS_BEST_STATE_EN
        output best_state,
        output best_pm,
`endif
        output norm
    );
endinterface

// File: rtl/acs_pm_unit_k3.sv
// acs_pm_unit_k3: add-compare-select and path-metric unit for the rate-1/2,
// K=3 (G0=7, G1=5) hard-decision Viterbi decoder.
// Each accepted step adds the four 2-bit branch metrics to the four stored
// path metrics. It keeps the survivor into every next state and emits one
// decision bit per state.
// Optional macro ACS_BEST_STATE_EN adds a registered best_state/best_pm
// output so traceback can start from the most likely state.
// The interface instance must use the same PM_W as this module.
module acs_pm_unit_k3 #(
    parameter int PM_W    = 6,
    parameter int INIT_PM = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    acs_pm_unit_k3_if.slave    bus
);

    // Candidate metrics carry one extra bit so the add never wraps before
    // the normalisation decision is made.
    localparam int              CW       = PM_W + 1;
    localparam logic [PM_W-1:0] INIT_V   = PM_W'(INIT_PM);
    localparam logic [CW-1:0]   NORM_THR = CW'(1) << (PM_W - 1);

    logic [PM_W-1:0] pm_q      [4];
    logic [PM_W-1:0] pm_d      [4];
    logic [3:0]      dec_q;
    logic [3:0]      dec_d;
    logic            dec_valid_q;
    logic            dec_valid_d;
    logic            norm_q;
    logic            norm_d;

    logic [1:0]      bm        [4];
    logic [PM_W-1:0] old_pm    [4];
    logic [CW-1:0]   new_pm    [4];
    logic [3:0]      sel;
    logic [CW-1:0]   min_lo;
    logic [CW-1:0]   min_hi;
    logic [CW-1:0]   min_pm;
    logic            do_norm;
    logic [CW-1:0]   sub_pm    [4];
    logic [PM_W-1:0] norm_pm   [4];

`ifdef ACS_BEST_STATE_EN
    logic [1:0]      best_state_q;
    logic [1:0]      best_state_d;
    logic [PM_W-1:0] best_pm_q;
    logic [PM_W-1:0] best_pm_d;
    logic [1:0]      cand_state;
    logic [PM_W-1:0] cand_pm;
`endif

    // Branch metrics indexed by codeword {c0,c1} so the ACS can look them up.
    always_comb begin
        bm[0] = bus.bm00;
        bm[1] = bus.bm01;
        bm[2] = bus.bm10;
        bm[3] = bus.bm11;
    end

    // Old metrics: a start-of-frame step runs from the init vector, not the registers.
    always_comb begin
        old_pm[0] = bus.sof ? '0     : pm_q[0];
        old_pm[1] = bus.sof ? INIT_V : pm_q[1];
        old_pm[2] = bus.sof ? INIT_V : pm_q[2];
        old_pm[3] = bus.sof ? INIT_V : pm_q[3];
    end

    // Butterfly per next state ns = {u,u1}. The predecessors are p0 = {u1,0}
    // and p1 = {u1,1}. On the p0 path u2 = 0, so c0 = u^u1 and c1 = u. The
    // p1 path flips u2, which inverts both code bits.
    for (genvar ns = 0; ns < 4; ns++) begin : g_acs
        localparam int U   = ns / 2;
        localparam int U1  = ns % 2;
        localparam int P0  = 2 * U1;
        localparam int P1  = P0 + 1;
        localparam int CW0 = 2 * (U ^ U1) + U;
        localparam int CW1 = 3 - CW0;

        logic [CW-1:0] cand0;
        logic [CW-1:0] cand1;

        assign cand0      = {1'b0, old_pm[P0]} + {{(CW-2){1'b0}}, bm[CW0]};
        assign cand1      = {1'b0, old_pm[P1]} + {{(CW-2){1'b0}}, bm[CW1]};
        // Strict compare: a tie keeps the p0 survivor.
        assign sel[ns]    = (cand1 < cand0);
        assign new_pm[ns] = sel[ns] ? cand1 : cand0;
    end

    // Normalise: once every metric has reached the top half, shift all of
    // them down by half the range. The bounded spread makes this lossless.
    always_comb begin
        min_lo  = (new_pm[1] < new_pm[0]) ? new_pm[1] : new_pm[0];
        min_hi  = (new_pm[3] < new_pm[2]) ? new_pm[3] : new_pm[2];
        min_pm  = (min_hi < min_lo) ? min_hi : min_lo;
        do_norm = (min_pm >= NORM_THR);
        for (int i = 0; i < 4; i++) begin
            sub_pm[i]  = new_pm[i] - (do_norm ? NORM_THR : '0);
            norm_pm[i] = sub_pm[i][PM_W-1:0];
        end
    end

`ifdef ACS_BEST_STATE_EN
    // Lowest post-normalisation metric, ties resolved to the lowest state index.
    always_comb begin
        cand_state = 2'd0;
        cand_pm    = norm_pm[0];
        for (int i = 1; i < 4; i++) begin
            if (norm_pm[i] < cand_pm) begin
                cand_state = 2'(i);
                cand_pm    = norm_pm[i];
            end
        end
    end
`endif

    // Next-state selection: accept a step, reload on a lone sof, or hold.
    always_comb begin
        pm_d        = pm_q;
        dec_d       = dec_q;
        norm_d      = norm_q;
        dec_valid_d = 1'b0;
`ifdef ACS_BEST_STATE_EN
        best_state_d = best_state_q;
        best_pm_d    = best_pm_q;
`endif
        if (bus.in_valid) begin
            pm_d        = norm_pm;
            dec_d       = sel;
            norm_d      = do_norm;
            dec_valid_d = 1'b1;
`ifdef ACS_BEST_STATE_EN
            best_state_d = cand_state;
            best_pm_d    = cand_pm;
`endif
        end else if (bus.sof) begin
            pm_d[0] = '0;
            pm_d[1] = INIT_V;
            pm_d[2] = INIT_V;
            pm_d[3] = INIT_V;
        end
    end

    // State registers; reset puts the metrics back at the frame-start vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q[0]     <= '0;
            pm_q[1]     <= INIT_V;
            pm_q[2]     <= INIT_V;
            pm_q[3]     <= INIT_V;
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
            norm_q      <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            dec_q       <= dec_d;
            dec_valid_q <= dec_valid_d;
            norm_q      <= norm_d;
        end
    end

`ifdef ACS_BEST_STATE_EN
    // Best-state registers, updated in step with the decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_state_q <= '0;
            best_pm_q    <= '0;
        end else begin
            best_state_q <= best_state_d;
            best_pm_q    <= best_pm_d;
        end
    end

    assign bus.best_state = best_state_q;
    assign bus.best_pm    = best_pm_q;
`endif

    assign bus.dec_valid = dec_valid_q;
    assign bus.dec       = dec_q;
    assign bus.norm      = norm_q;
    assign bus.pm_flat   = {pm_q[3], pm_q[2], pm_q[1], pm_q[0]};

endmodule
